// File: rtl/b1_eval_pkg.sv
// Shared types and constants for the b1 evaluation arbiter: FSM states,
// result bit positions and counter widths.
package b1_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Bit positions inside the 4-bit result {po3,po2,po1,po0}.
  localparam int PO0 = 0;
  localparam int PO1 = 1;
  localparam int PO2 = 2;
  localparam int PO3 = 3;

  // Width of the visible clock-zone output and of the internal phase counter.
  localparam int PHASE_W = 2;
  localparam int PCNT_W  = 4;

endpackage

// File: rtl/b1_eval_if.sv
// Request/response bundle between the requesters, the result consumer and
// the evaluation arbiter.
interface b1_eval_if
  import b1_eval_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [3:0]           rsp_data;
  logic [PHASE_W-1:0]   phase;
  logic                 busy;
  logic [15:0]          eval_count;

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, phase, busy, eval_count
  );

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, phase, busy, eval_count
  );

endinterface

// File: rtl/b1_eval_core.sv
// Combinational evaluator: maps a 3-bit operand {pi2,pi1,pi0} to the 4-bit
// result {po3,po2,po1,po0}.
module b1_eval_core
  import b1_eval_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [3:0] res_o
);

  logic pi0, pi1, pi2;

  assign pi0 = op_i[0];
  assign pi1 = op_i[1];
  assign pi2 = op_i[2];

  always_comb begin
    res_o      = '0;
    res_o[PO0] = pi2;
    res_o[PO1] = pi0 ^ pi1;
    res_o[PO2] = (pi0 & pi1 & ~pi2) | (~pi0 & ~pi1 & pi2);
    res_o[PO3] = ~pi2;
  end

endmodule

// File: rtl/b1_eval_arbiter.sv
// Round-robin arbiter feeding one shared multi-phase evaluator; each accepted
// operand is evaluated over PHASES cycles and held as a response until taken.
module b1_eval_arbiter
  import b1_eval_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PHASES  = 4
)(
  input  logic      clk,
  input  logic      rst_n,
  b1_eval_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
  logic [2:0]           op_q, op_d;
  logic [3:0]           rsp_data_q, rsp_data_d;
  logic [15:0]          eval_count_q, eval_count_d;

  logic [3:0]           core_res;
  logic                 grant_any;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      cand;
  logic [NUM_REQ-1:0]   req_ready_c;

  b1_eval_core u_core (
    .op_i  (op_q),
    .res_o (core_res)
  );

  // Scan from the farthest candidate back to rr_ptr so the nearest valid
  // requester at or after the pointer is the last one written.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    pcnt_d       = pcnt_q;
    op_d         = op_q;
    rsp_data_d   = rsp_data_q;
    eval_count_d = eval_count_q;
    req_ready_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready_c[grant_idx] = 1'b1;
          op_d     = bus.req_data[3*int'(grant_idx) +: 3];
          id_d     = grant_idx;
          rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          pcnt_d   = '0;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (pcnt_q == PCNT_W'(PHASES - 1)) begin
          rsp_data_d = core_res;
          pcnt_d     = '0;
          state_d    = ST_RESP;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          eval_count_d = (eval_count_q == 16'hFFFF) ? eval_count_q : eval_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      pcnt_q       <= '0;
      op_q         <= '0;
      rsp_data_q   <= '0;
      eval_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      pcnt_q       <= pcnt_d;
      op_q         <= op_d;
      rsp_data_q   <= rsp_data_d;
      eval_count_q <= eval_count_d;
    end
  end

  // The accept strobe is combinational from req_valid, so it is gated by
  // rst_n to drop the instant reset asserts rather than at the next edge.
  assign bus.req_ready  = rst_n ? req_ready_c : '0;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.phase      = (state_q == ST_EVAL) ? pcnt_q[PHASE_W-1:0] : '0;
  assign bus.eval_count = eval_count_q;

endmodule

// File: doc/b1_eval_arbiter.md
B1_EVAL_ARBITER -- requirements
Module: b1_eval_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the evaluator (2..8).
REQ-002 Parameter PHASES, default 4, evaluation phases per operation, modelling the 4-phase FCN clocking zones (1..15).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 Port req_data  input  3*NUM_REQ  operands; requester i occupies bits [3i+2:3i] = {pi2,pi1,pi0}.
REQ-007 Port req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-008 Port rsp_valid  output  1  result valid.
REQ-009 Port rsp_ready  input  1  result consumer ready.
REQ-010 Port rsp_id  output  $clog2(NUM_REQ)  index of the requester owning the result.
REQ-011 Port rsp_data  output  4  result {po3,po2,po1,po0}.
REQ-012 Port phase  output  2  current clock zone (phase counter mod 4); 0 outside EVAL.
REQ-013 Port busy  output  1  high in EVAL or RESP.
REQ-014 Port eval_count  output  16  completed-response counter.

Function
REQ-015 The FSM SHALL have states IDLE, EVAL and RESP.
REQ-016 In IDLE with any req_valid set, the block SHALL grant the first valid requester at or after rr_ptr (cyclic), assert that requester's req_ready for exactly that cycle, latch its operand and index, and move to EVAL.
REQ-017 req_ready SHALL be zero in all states except the IDLE accept cycle, and at most one bit SHALL be set.
REQ-018 rr_ptr SHALL update on each accept to (granted index + 1) mod NUM_REQ; a requester that drops req_valid before its grant loses nothing.
REQ-019 EVAL SHALL last exactly PHASES cycles, with the phase counter running 0..PHASES-1, then move to RESP.
REQ-020 In RESP, rsp_valid SHALL be high, with rsp_id and rsp_data stable until rsp_ready is sampled high; on that handshake the FSM SHALL go to IDLE.
REQ-021 Accept-to-rsp_valid latency SHALL be PHASES+1 cycles; with rsp_ready held high, back-to-back throughput SHALL be one result per PHASES+2 cycles.
REQ-022 The result SHALL be computed from the latched operand: po0=pi2; po1=pi0^pi1; po2=(pi0&pi1&~pi2)|(~pi0&~pi1&pi2); po3=~pi2.
REQ-023 req_valid/req_data changes after accept SHALL NOT affect the in-flight result.
REQ-024 eval_count SHALL increment by 1 on each rsp handshake and saturate at 16'hFFFF.

Reset
REQ-025 Asserting rst_n low SHALL immediately force the following, discarding any in-flight operation: state IDLE, rr_ptr 0, phase counter 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, eval_count 0.
REQ-026 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-027 A shared package b1_eval_pkg SHALL hold the FSM state enum, the result bit-position constants and the phase-width constant.
REQ-028 The combinational function SHALL live in one sub-module b1_eval_core (3-bit operand in, 4-bit result out), instantiated once.

Verification
REQ-029 Single request: after reset, req0 data 3'b011 -> req_ready=4'b0001 in the request cycle; rsp_valid 5 cycles later with rsp_id=0, rsp_data=4'b1100.
REQ-030 Round-robin: all four requesters held valid with rsp_ready=1 -> grant order 0,1,2,3,0, with accepts spaced 6 cycles apart.
REQ-031 Backpressure: req2 data 3'b100 with rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id=2 and rsp_data=4'b0101 held stable, no new req_ready, and eval_count unchanged until rsp_ready=1.
REQ-032 Reset mid-EVAL: drop rst_n during phase 2 -> all outputs zero at once; after release, req1 data 3'b101 yields rsp_data=4'b0011 and eval_count=1.
REQ-033 Exhaustive: all 8 operands on each requester -> every rsp_data matches REQ-022; phase cycles 0,1,2,3 during each EVAL.
REQ-034 Saturation: force 65540 handshakes -> eval_count stays at 16'hFFFF.
